// File: rtl/vga_mem_arbiter_if.sv
// Bus bundle between the VGA memory arbiter, the writer (text/graphics update
// logic) and the single-port synchronous video RAM.
//   wr_req/wr_addr/wr_data : writer request, held until wr_ack
//   wr_ack                 : one-cycle pulse in the cycle the write is issued
//   mem_addr/mem_we/mem_wdata : registered RAM command from the arbiter
//   mem_rdata              : RAM read data, valid 1 clk after the address cycle
// Modport slave is the arbiter view; master is the writer + RAM view.
interface vga_mem_arbiter_if #(
  parameter int DW = 8,
  parameter int AW = 13
);
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  wr_req, wr_addr, wr_data, mem_rdata,
    output wr_ack, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output wr_req, wr_addr, wr_data, mem_rdata,
    input  wr_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_mem_arbiter.sv
// Shares one single-port synchronous video RAM between VGA scan-out and one
// writer. Display fetches (one cell per pixel tick) have absolute priority;
// the writer gets leftover slots through a req/ack handshake.
// Ports:
//   clk, reset         : system clock (4x pixel rate), async active-high reset
//   tick, video_on     : pixel tick and visible-area flag from sync generator
//   pixelx, pixely     : current pixel coordinates, valid with tick
//   bus                : writer handshake + RAM command/data (slave modport)
//   pix_data, pix_valid: last fetched cell and its one-cycle update strobe
module vga_mem_arbiter #(
  parameter int DW    = 8,
  parameter int AW    = 13,
  parameter int SHIFT = 3,
  parameter int COLS  = 80
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          video_on,
  input  logic [9:0]    pixelx,
  input  logic [9:0]    pixely,
  vga_mem_arbiter_if.slave bus,
  output logic [DW-1:0] pix_data,
  output logic          pix_valid
);

  typedef enum logic [1:0] {IDLE, DISP, CAPT, WRITE} state_t;

  state_t        state;
  logic          pend;
  logic [AW-1:0] disp_addr_q;

  logic          vis_tick;
  logic          disp_due;
  logic [AW-1:0] disp_addr_now;
  logic [AW-1:0] disp_src;

  always_comb begin
    vis_tick      = tick & video_on;
    disp_due      = pend | vis_tick;
    disp_addr_now = AW'(32'(pixely >> SHIFT) * 32'(COLS) + 32'(pixelx >> SHIFT));
    // A tick in this very cycle has not reached disp_addr_q yet.
    disp_src      = vis_tick ? disp_addr_now : disp_addr_q;
  end

  // RAM command outputs are registered on the transition into DISP/WRITE so
  // they are valid for the whole cycle the FSM spends in that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      pend          <= 1'b0;
      disp_addr_q   <= '0;
      bus.mem_addr  <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_wdata <= '0;
      bus.wr_ack    <= 1'b0;
      pix_data      <= '0;
      pix_valid     <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      bus.wr_ack <= 1'b0;
      pix_valid  <= 1'b0;

      if (vis_tick) begin
        pend        <= 1'b1;
        disp_addr_q <= disp_addr_now;
      end else if (state == DISP) begin
        pend <= 1'b0;
      end

      if (tick && !video_on) begin
        pix_data <= '0;
      end

      case (state)
        IDLE: begin
          if (disp_due) begin
            state        <= DISP;
            bus.mem_addr <= disp_src;
          end else if (bus.wr_req) begin
            state         <= WRITE;
            bus.mem_addr  <= bus.wr_addr;
            bus.mem_wdata <= bus.wr_data;
            bus.mem_we    <= 1'b1;
            bus.wr_ack    <= 1'b1;
          end
        end
        DISP: begin
          state <= CAPT;
        end
        CAPT: begin
          // Overrides the blanking clear above; never coincides with a
          // tick when ticks arrive every 4 clk.
          state     <= IDLE;
          pix_data  <= bus.mem_rdata;
          pix_valid <= 1'b1;
        end
        WRITE: begin
          if (disp_due) begin
            state        <= DISP;
            bus.mem_addr <= disp_src;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/vga_mem_arbiter.md
# vga_mem_arbiter

Shares one single-port synchronous video RAM between the VGA scan-out path and a single writer (text/graphics update logic). It sits beside the VGA sync generator: it consumes that generator's `tick`, `video_on`, `pixelx` and `pixely`, fetches one cell per pixel tick, and presents `pix_data` to the colour logic. Display reads have absolute priority. The writer uses the RAM slots left over, through a req/ack handshake.

## Interface
- `DW`, 8: RAM data width.
- `AW`, 13: RAM address width.
- `SHIFT`, 3: log2 of cell size in pixels (8x8 cells).
- `COLS`, 80: cells per row.

- `clk`  in  1  system clock (4x pixel rate).
- `reset`  in  1  asynchronous, active-high; one clock domain only.
- `tick`  in  1  pixel tick from sync generator, one clk wide, every 4 clk.
- `video_on`  in  1  visible-area flag, valid with `tick`.
- `pixelx`, `pixely`  in  10 each  current pixel coordinates, valid with `tick`.
- `wr_req`  in  1  write request; held until `wr_ack`.
- `wr_addr`  in  AW  write address; stable while `wr_req`=1.
- `wr_data`  in  DW  write data; stable while `wr_req`=1.
- `wr_ack`  out  1  one-cycle pulse, high in the cycle the write is issued.
- `mem_addr`  out  AW  RAM address (registered).
- `mem_we`  out  1  RAM write enable (registered).
- `mem_wdata`  out  DW  RAM write data (registered).
- `mem_rdata`  in  DW  RAM read data, valid 1 clk after the address cycle.
- `pix_data`  out  DW  last fetched cell; held between updates.
- `pix_valid`  out  1  one-cycle pulse when `pix_data` updates from RAM.

## Operation
- Display address is `((pixely>>SHIFT)*COLS + (pixelx>>SHIFT))`, truncated to AW bits. For defaults the range is 0..4799.
- When `tick` is high:
  - If `video_on`=1: latch the display address into `disp_addr_q` and set `pend`.
  - If `video_on`=0: no read. Clear `pix_data` to 0 at that edge. `pix_valid` stays 0.
- State machine (one state per clk): `IDLE`, `DISP`, `CAPT`, `WRITE`.
  - `IDLE`: if `pend` or (`tick`&`video_on`), go to `DISP`. Else if `wr_req`, go to `WRITE`. Else stay.
  - `DISP`: drives `mem_addr`=display address, `mem_we`=0; clears `pend` unless a new visible tick arrives this cycle. Next state `CAPT`.
  - `CAPT`: `mem_rdata` is valid; `pix_data`<=`mem_rdata`, and `pix_valid` is 1 in the following cycle. Next state `IDLE`.
  - `WRITE`: drives `mem_addr`=`wr_addr`, `mem_wdata`=`wr_data`, `mem_we`=1; `wr_ack`=1. Next state: `DISP` if `pend` or visible `tick`, else `IDLE`.
- A tick arriving in any state is never lost; `pend` holds it.
- A write is never aborted once in `WRITE`.
- Simultaneous `tick`&`video_on` and `wr_req` in `IDLE`: display wins; the writer waits.
- `wr_addr` is not range-checked.
- When `mem_we`=0 outside `WRITE`, `mem_wdata` holds its last value.

## Timing
- Reset values (all asynchronous):
  - State `IDLE`; `pend`=0, `disp_addr_q`=0.
  - `mem_addr`=0, `mem_we`=0, `mem_wdata`=0.
  - `pix_data`=0, `pix_valid`=0, `wr_ack`=0.
- Read latency, visible tick at cycle T with no collision: `DISP` at T+1, `CAPT` at T+2, `pix_valid` at T+3.
- If a write occupies T+1, `pix_valid` moves to T+4. It is never later than T+4.
- Write latency with no display traffic: `wr_req` rising at T gives `WRITE`/`wr_ack` at T+1.
- Steady state with display active and `wr_req` held: at most 1 write per 4-clk pixel period, no display fetch missed.
- During blanking: 1 write per 2 clk (`WRITE`, `IDLE`, ...).
- Reset asserted mid-read or mid-write: all outputs go to reset values immediately; no `wr_ack` is issued for the interrupted write, and the writer must re-request.

## Test plan
- Reset mid-`WRITE` (after `mem_we`=1): all outputs 0 immediately. After release, held `wr_req` produces a fresh `wr_ack`.
- `pixelx`=17, `pixely`=9, `video_on`=1, `tick` at T, `mem_rdata`=8'hA5:
  - `mem_addr`=82 and `mem_we`=0 at T+1.
  - `pix_data`=8'hA5 and `pix_valid`=1 at T+3 only.
- `wr_req` with `wr_addr`=100, `wr_data`=8'h3C during blanking: `mem_we`=1, `mem_addr`=100, `mem_wdata`=8'h3C and `wr_ack`=1 exactly one cycle after request. `wr_ack` returns to 0 next cycle.
- `wr_req` and visible `tick` in the same `IDLE` cycle:
  - `DISP` runs first.
  - `WRITE` is not issued before `pix_valid`.
  - No display fetch is dropped over 100 consecutive ticks.
- `WRITE` in the cycle a visible tick arrives: `pend` set; `DISP` in the next cycle with the latched address; `pix_valid` 4 clk after the tick.
- `tick` with `video_on`=0: `pix_data`=0 after that edge, no `DISP`, `pix_valid` stays 0.
